// File: rtl/fib_result_reader_pkg.sv
// Shared definitions for the result-RAM writer (generation controller) and reader.
// Holds the default widths, the last result address and the reader state encoding.
package fib_result_reader_pkg;

    localparam int RESULT_DATA_W    = 32;
    localparam int RESULT_ADDR_W    = 6;
    localparam int RESULT_LAST_ADDR = 29;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        ISSUE   = ST_ISSUE,
        CAPTURE = ST_CAPTURE,
        HOLD    = ST_HOLD,
        DONE    = ST_DONE
    } state_t;

endpackage

// File: rtl/fib_result_reader_if.sv
// Valid/ready word stream from the result reader to the display/UART sink.
interface fib_result_reader_if
    import fib_result_reader_pkg::*;
#(
    parameter int DATA_W = RESULT_DATA_W
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/fib_checksum_acc.sv
// Wrapping accumulator with synchronous clear; clear wins over enable.
module fib_checksum_acc
    import fib_result_reader_pkg::*;
#(
    parameter int DATA_W = RESULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] sum
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   sum <= '0;
        else if (clr) sum <= '0;
        else if (en)  sum <= sum + din;
    end

endmodule

// File: rtl/fib_result_reader.sv
// Reads result RAM words 0..LAST_ADDR after a start pulse and streams them out
// on a valid/ready port, keeping a running checksum of accepted words.
module fib_result_reader
    import fib_result_reader_pkg::*;
#(
    parameter int DATA_W    = RESULT_DATA_W,
    parameter int ADDR_W    = RESULT_ADDR_W,
    parameter int LAST_ADDR = RESULT_LAST_ADDR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               ram_en,
    output logic [ADDR_W-1:0]  ram_addr,
    input  logic [DATA_W-1:0]  ram_rdata,
    fib_result_reader_if.master out_if,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  checksum
);

    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(LAST_ADDR);

    state_t state;
    logic   accept_start;
    logic   accept_word;

    // start only counts from a resting state; mid-pass pulses are dropped
    assign accept_start = start && (state == IDLE || state == DONE);
    assign accept_word  = (state == HOLD) && out_if.out_ready;
    assign busy         = (state == ISSUE) || (state == CAPTURE) || (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            ram_en           <= 1'b0;
            ram_addr         <= '0;
            out_if.out_data  <= '0;
            out_if.out_valid <= 1'b0;
            out_if.out_last  <= 1'b0;
            done             <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept_start) begin
                        ram_addr <= '0;
                        ram_en   <= 1'b1;
                        done     <= 1'b0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // RAM samples ram_addr at this edge; data lands next cycle
                    ram_en <= 1'b0;
                    state  <= CAPTURE;
                end
                CAPTURE: begin
                    out_if.out_data  <= ram_rdata;
                    out_if.out_valid <= 1'b1;
                    out_if.out_last  <= (ram_addr == LAST_A);
                    state            <= HOLD;
                end
                HOLD: begin
                    if (out_if.out_ready) begin
                        out_if.out_valid <= 1'b0;
                        out_if.out_last  <= 1'b0;
                        if (ram_addr == LAST_A) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            ram_addr <= ram_addr + 1'b1;
                            ram_en   <= 1'b1;
                            state    <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fib_checksum_acc #(.DATA_W(DATA_W)) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept_start),
        .en    (accept_word),
        .din   (out_if.out_data),
        .sum   (checksum)
    );

endmodule

// File: tb/tb_fib_result_reader.sv
// Bench for fib_result_reader: RAM model, queue-free word-order model checked
// every cycle, plus directed passes with hand-computed checksums and latencies.
module tb_fib_result_reader;
    import fib_result_reader_pkg::*;

    localparam int DW   = 32;
    localparam int AW   = 6;
    localparam int LAST = 29;
    localparam int NW   = LAST + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_rdata = '0;
    logic          busy, done;
    logic [DW-1:0] checksum;

    fib_result_reader_if #(.DATA_W(DW)) sif ();

    fib_result_reader #(.DATA_W(DW), .ADDR_W(AW), .LAST_ADDR(LAST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ram_en    (ram_en),
        .ram_addr  (ram_addr),
        .ram_rdata (ram_rdata),
        .out_if    (sif),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:63];
    always @(posedge clk) if (ram_en) ram_rdata <= mem[ram_addr];

    // ready source: fixed level or a repeating 1-0-0-1 pattern
    logic     rdy_fixed = 1'b0;
    logic     rdy_toggle = 1'b0;
    logic     pat_bit = 1'b0;
    logic [3:0] pat = 4'b1001;
    int       rk = 0;
    assign sif.out_ready = rdy_toggle ? pat_bit : rdy_fixed;
    always @(posedge clk) begin
        #1;
        pat_bit = pat[rk % 4];
        rk++;
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // model state: which word of the pass is due next, and its running sum
    logic          m_active = 1'b0;
    logic          m_done = 1'b0;
    logic [DW-1:0] m_sum = '0;
    int            acc_cnt = 0;
    int            ren_cnt = 0;
    int            last_cnt = 0;
    logic [DW-1:0] last_data = '0;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_active = 1'b0; m_done = 1'b0; m_sum = '0;
            acc_cnt = 0; ren_cnt = 0; last_cnt = 0; prev_hold = 1'b0;
        end else begin
            chk("busy", busy, m_active);
            chk("done", done, m_done);
            chk("checksum", checksum, m_sum);
            if (ram_en) begin
                ren_cnt++;
                chk("ram_en_outside_pass", busy, 1);
                chk("ram_en_with_valid", sif.out_valid, 0);
            end
            if (prev_hold) begin
                chk("hold_valid", sif.out_valid, 1);
                chk("hold_data", sif.out_data, prev_data);
                chk("hold_last", sif.out_last, prev_last);
            end
            if (sif.out_valid) begin
                if (acc_cnt < NW && m_active) begin
                    chk("word_data", sif.out_data, mem[acc_cnt]);
                    chk("word_last", sif.out_last, (acc_cnt == LAST));
                end else begin
                    chk("extra_word", 1, 0);
                end
            end else begin
                chk("last_without_valid", sif.out_last, 0);
            end
            prev_hold = sif.out_valid && !sif.out_ready;
            prev_data = sif.out_data;
            prev_last = sif.out_last;
            // predictions for the coming edge: start first, using pre-edge activity
            if (start && !m_active) begin
                m_active = 1'b1; m_done = 1'b0; m_sum = '0;
                acc_cnt = 0; ren_cnt = 0; last_cnt = 0;
            end else if (sif.out_valid && sif.out_ready && m_active && acc_cnt < NW) begin
                m_sum = m_sum + mem[acc_cnt];
                if (sif.out_last) last_cnt++;
                last_data = sif.out_data;
                acc_cnt++;
                if (acc_cnt == NW) begin
                    m_active = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    end

    task automatic fill_fib();
        logic [DW-1:0] a, b, t;
        a = 1; b = 1;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        for (int i = 0; i < NW; i++) begin
            mem[i] = a;
            t = a + b; a = b; b = t;
        end
    endtask

    task automatic fill_ones();
        for (int i = 0; i < 64; i++) mem[i] = (i < NW) ? 32'hFFFF_FFFF : 32'h0;
    endtask

    // call at posedge+1; returns cycles from the start edge to done and first-valid cycle
    task automatic run_pass(input string tag, output int cyc, output int fv);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; fv = -1;
        chk({tag, "_start_clears_done"}, done, 0);
        chk({tag, "_start_clears_sum"}, checksum, 0);
        chk({tag, "_busy_after_start"}, busy, 1);
        while (!done && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
            if (fv < 0 && sif.out_valid) fv = cyc;
        end
        if (!done) chk({tag, "_pass_timeout"}, 0, 1);
    endtask

    task automatic check_pass(input string tag, input logic [DW-1:0] exp_sum, input logic [DW-1:0] exp_last);
        chk({tag, "_checksum"}, checksum, exp_sum);
        chk({tag, "_words"}, acc_cnt, NW);
        chk({tag, "_last_flags"}, last_cnt, 1);
        chk({tag, "_last_word"}, last_data, exp_last);
        chk({tag, "_ram_reads"}, ren_cnt, NW);
    endtask

    int cyc, fv, guard;

    initial begin
        fill_fib();
        #1 rst_n = 1'b0;
        #10;
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_out_valid", sif.out_valid, 0);
        chk("rst_out_data", sif.out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_checksum", checksum, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // full pass, ready always high
        rdy_fixed = 1'b1;
        run_pass("t1", cyc, fv);
        chk("t1_first_valid_cycle", fv, 2);
        chk("t1_done_cycle", cyc, 90);
        check_pass("t1", 32'd2178308, 32'd832040);

        // immediate restart from DONE must repeat the pass exactly
        run_pass("t6", cyc, fv);
        chk("t6_done_cycle", cyc, 90);
        check_pass("t6", 32'd2178308, 32'd832040);

        // ready pattern 1-0-0-1 with stalls
        rdy_toggle = 1'b1;
        run_pass("t2", cyc, fv);
        check_pass("t2", 32'd2178308, 32'd832040);
        rdy_toggle = 1'b0;

        // start pulses mid-pass are ignored
        fork
            run_pass("t3", cyc, fv);
            begin
                guard = 0;
                while (acc_cnt < 5 && guard < 500) begin @(posedge clk); #1; guard++; end
                start = 1'b1; @(posedge clk); #1; start = 1'b0;
                while (acc_cnt < 12 && guard < 500) begin @(posedge clk); #1; guard++; end
                start = 1'b1; @(posedge clk); #1; start = 1'b0;
            end
        join
        chk("t3_done_cycle", cyc, 90);
        check_pass("t3", 32'd2178308, 32'd832040);

        // all-ones words wrap the checksum
        fill_ones();
        run_pass("t5", cyc, fv);
        check_pass("t5", 32'hFFFF_FFE2, 32'hFFFF_FFFF);

        // async reset while holding word at address 10
        fill_fib();
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        guard = 0;
        while (acc_cnt < 10 && guard < 500) begin @(posedge clk); #1; guard++; end
        rdy_fixed = 1'b0;
        while (!sif.out_valid && guard < 500) begin @(posedge clk); #1; guard++; end
        chk("t4_hold_valid", sif.out_valid, 1);
        chk("t4_hold_addr", ram_addr, 10);
        chk("t4_hold_data", sif.out_data, 32'd89);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_rst_ram_en", ram_en, 0);
        chk("t4_rst_ram_addr", ram_addr, 0);
        chk("t4_rst_out_data", sif.out_data, 0);
        chk("t4_rst_out_valid", sif.out_valid, 0);
        chk("t4_rst_out_last", sif.out_last, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_done", done, 0);
        chk("t4_rst_checksum", checksum, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_addr", ram_addr, 0);
        rdy_fixed = 1'b1;
        run_pass("t4", cyc, fv);
        chk("t4_first_valid_cycle", fv, 2);
        chk("t4_done_cycle", cyc, 90);
        check_pass("t4", 32'd2178308, 32'd832040);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fib_result_reader.md
Name: fib_result_reader

Overview:
- Read-side counterpart of the sequence-generation controller, which writes computed results into the result RAM.
- After a start pulse, walks RAM addresses 0..LAST_ADDR in order, one synchronous read per word.
- Presents each word on a valid/ready output stream for the display/UART sink.
- Accumulates a running checksum so completion and result integrity can be checked.

Parameters:
- DATA_W, 32, width of RAM words and output data.
- ADDR_W, 6, width of RAM address.
- LAST_ADDR, 29, final address read; words transferred = LAST_ADDR+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- start  in  1  single-cycle request to begin a readback pass.
- ram_en  out  1  RAM read enable, registered.
- ram_addr  out  ADDR_W  RAM read address, registered.
- ram_rdata  in  DATA_W  RAM read data; valid one cycle after the edge that samples ram_en=1 (fixed latency 1).
- out_data  out  DATA_W  current output word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts the word when out_valid and out_ready are both 1 at a rising edge.
- out_last  out  1  high with out_valid on the word from LAST_ADDR.
- busy  out  1  pass in progress (state not IDLE/DONE).
- done  out  1  pass complete; held until the next accepted start.
- checksum  out  DATA_W  sum mod 2^DATA_W of all accepted words in the current pass.

Behaviour:
- Reset (rst_n=0, any time, including mid-pass): state=IDLE. All outputs clear immediately: ram_en=0, ram_addr=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0, checksum=0. Any in-flight transfer is abandoned.
- States: IDLE, ISSUE, CAPTURE, HOLD, DONE.
- IDLE or DONE, start=1: ram_addr<=0, ram_en<=1, checksum<=0, done<=0, state<=ISSUE.
- ISSUE: ram_en<=0, state<=CAPTURE. The RAM samples the address at this edge.
- CAPTURE: out_data<=ram_rdata, out_valid<=1, out_last<=(ram_addr==LAST_ADDR), state<=HOLD.
- HOLD, out_ready=0: all outputs hold. out_data and out_last stay stable while out_valid=1.
- HOLD, out_ready=1: checksum<=checksum+out_data (wraps mod 2^DATA_W), out_valid<=0, out_last<=0. Then:
  - If ram_addr==LAST_ADDR: done<=1, state<=DONE.
  - Else: ram_addr<=ram_addr+1, ram_en<=1, state<=ISSUE.
- Latency:
  - out_valid rises at the 2nd rising edge after the edge that samples start.
  - Minimum 3 cycles per word with out_ready held at 1.
  - Full pass with out_ready=1: 3*(LAST_ADDR+1) cycles from the start edge to done=1.
- start while busy=1: ignored; no restart, no state change.
- start in DONE: new pass; done and checksum clear at that edge.
- out_ready while out_valid=0: ignored.
- ram_en is asserted for exactly one cycle per word and is never asserted outside ISSUE.
- busy is 1 in ISSUE/CAPTURE/HOLD, derived from registered state.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE, ISSUE, CAPTURE, HOLD, DONE, 3-bit);
  - shared DATA_W/ADDR_W defaults, also used by the generation controller;
  - RESULT_LAST_ADDR = 29.
- One sub-module is natural: fib_checksum_acc (accumulator with clear and enable; async active-low reset).
- Everything else stays flat in one FSM.

Test Plan:
1. Preload RAM[i]=F(i+1) (1,1,2,...,832040); pulse start; out_ready=1 -> 30 words in order; out_last only on 832040; done=1 at 90 cycles after start; checksum=2178308.
2. Same preload; out_ready toggles 1-0-0-1 pattern -> no word dropped or duplicated; out_data stable while valid and not ready; checksum=2178308.
3. start pulses at words 5 and 12 of a running pass -> ignored; sequence and checksum unchanged; single done.
4. rst_n=0 asynchronously while in HOLD at address 10 -> all outputs 0 immediately; after release, state IDLE; new start reads from address 0.
5. RAM filled with 32'hFFFF_FFFF, 30 words -> checksum=32'hFFFF_FFE2 (wrap); out_last on word 30 only.
6. After done, pulse start -> done drops at that edge; checksum restarts from 0; second pass identical to the first.
